ir_key_decoder: RTL and testbench

Downstream stage of the NEC IR receiver. Consumes each 32-bit frame and repeat-code strobe, checks the frame's complement fields, and latches address/command for the FND display path. Tracks key-hold via repeat codes with a release timeout, and emits press/repeat/release/error event pulses.

---
 rtl/ir_key_decoder.sv | 146 ++++++++++++++
 tb/tb_ir_key_decoder.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/ir_key_decoder.sv
// ---------------------------------------------------------------------------
// ir_key_decoder
//
// Downstream stage of the NEC IR receiver. Validates each received 32-bit
// frame against its complement fields, latches address/command for the FND
// display path, and tracks key-hold through repeat codes with a release
// timeout. Emits one-cycle press / repeat / release / error pulses.
//
// Parameters:
//   EXT_ADDR    - 0: standard NEC, address byte checked against its inverse
//                 1: extended NEC, 16-bit address, no address check
//   TIMEOUT_CYC - clk cycles without a repeat or frame before a held key
//                 is released
//
// Ports:
//   clk         - system clock
//   rst_n       - asynchronous, active-low reset
//   i_data      - frame: [31:24] addr, [23:16] ~addr / addr high, [15:8] cmd,
//                 [7:0] ~cmd
//   i_valid     - one-clk strobe, i_data complete
//   i_repeat    - one-clk strobe, repeat code detected
//   o_addr      - last accepted address
//   o_cmd       - last accepted command
//   o_key_valid - pulse: new accepted frame
//   o_rep       - pulse: accepted repeat while held
//   o_release   - pulse: hold timeout expired
//   o_err       - pulse: frame failed complement check
//   o_held      - level: key currently held
//   o_rep_cnt   - repeats since last accepted frame, saturating at 255
// ---------------------------------------------------------------------------
module ir_key_decoder #(
  parameter bit          EXT_ADDR    = 1'b0,
  parameter int unsigned TIMEOUT_CYC = 6000000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] i_data,
  input  logic        i_valid,
  input  logic        i_repeat,
  output logic [15:0] o_addr,
  output logic [7:0]  o_cmd,
  output logic        o_key_valid,
  output logic        o_rep,
  output logic        o_release,
  output logic        o_err,
  output logic        o_held,
  output logic [7:0]  o_rep_cnt
);

  typedef enum logic {
    IDLE,
    HELD
  } state_t;

  localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT_CYC - 1);

  state_t      state;
  logic [31:0] timer;

  logic        cmd_ok;
  logic        addr_ok;
  logic        frame_good;
  logic [15:0] frame_addr;

  assign cmd_ok     = (i_data[15:8] == ~i_data[7:0]);
  assign addr_ok    = EXT_ADDR ? 1'b1 : (i_data[31:24] == ~i_data[23:16]);
  assign frame_good = cmd_ok & addr_ok;
  assign frame_addr = EXT_ADDR ? {i_data[23:16], i_data[31:24]}
                               : {8'h00, i_data[31:24]};

  // Single FSM with registered outputs. Pulses default low each cycle.
  // i_valid has priority over i_repeat, and any strobe beats the timeout.
  // The expiry test uses >= so that a bad frame arriving exactly on the
  // expiry cycle (which lets the timer step past the limit) still releases
  // on the following cycle instead of holding forever.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      timer       <= '0;
      o_addr      <= '0;
      o_cmd       <= '0;
      o_key_valid <= 1'b0;
      o_rep       <= 1'b0;
      o_release   <= 1'b0;
      o_err       <= 1'b0;
      o_held      <= 1'b0;
      o_rep_cnt   <= '0;
    end else begin
      o_key_valid <= 1'b0;
      o_rep       <= 1'b0;
      o_release   <= 1'b0;
      o_err       <= 1'b0;

      case (state)
        IDLE: begin
          if (i_valid) begin
            if (frame_good) begin
              o_addr      <= frame_addr;
              o_cmd       <= i_data[15:8];
              o_key_valid <= 1'b1;
              o_rep_cnt   <= '0;
              timer       <= '0;
              o_held      <= 1'b1;
              state       <= HELD;
            end else begin
              o_err <= 1'b1;
            end
          end
        end

        HELD: begin
          if (i_valid) begin
            if (frame_good) begin
              o_addr      <= frame_addr;
              o_cmd       <= i_data[15:8];
              o_key_valid <= 1'b1;
              o_rep_cnt   <= '0;
              timer       <= '0;
            end else begin
              o_err <= 1'b1;
              timer <= timer + 32'd1;
            end
          end else if (i_repeat) begin
            o_rep <= 1'b1;
            timer <= '0;
            if (o_rep_cnt != 8'hFF) begin
              o_rep_cnt <= o_rep_cnt + 8'd1;
            end
          end else if (timer >= TIMEOUT_LAST) begin
            o_release <= 1'b1;
            o_held    <= 1'b0;
            timer     <= '0;
            state     <= IDLE;
          end else begin
            timer <= timer + 32'd1;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ir_key_decoder.sv
// ---------------------------------------------------------------------------
// tb_ir_key_decoder
//
// Self-checking bench for ir_key_decoder. Two instances share the stimulus:
// a standard-NEC instance and an extended-NEC instance, both with a short
// 100-cycle release timeout. A vector table covers single-cycle behaviour;
// hand-written sequences cover timeout, saturation and mid-hold reset.
//
// Output bundle layout used for comparisons (37 bits):
//   {key_valid, rep, release, err, held, addr[15:0], cmd[7:0], rep_cnt[7:0]}
// ---------------------------------------------------------------------------
module tb_ir_key_decoder;

  localparam int unsigned TO = 100;

  logic        clk;
  logic        rst_n;
  logic [31:0] i_data;
  logic        i_valid;
  logic        i_repeat;

  logic [15:0] s_addr;
  logic [7:0]  s_cmd;
  logic        s_kv, s_rep, s_rel, s_err, s_held;
  logic [7:0]  s_cnt;

  logic [15:0] x_addr;
  logic [7:0]  x_cmd;
  logic        x_kv, x_rep, x_rel, x_err, x_held;
  logic [7:0]  x_cnt;

  logic [36:0] act_std;
  logic [36:0] act_ext;

  int checks;
  int fails;

  ir_key_decoder #(.EXT_ADDR(1'b0), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst_n(rst_n), .i_data(i_data), .i_valid(i_valid),
    .i_repeat(i_repeat), .o_addr(s_addr), .o_cmd(s_cmd),
    .o_key_valid(s_kv), .o_rep(s_rep), .o_release(s_rel), .o_err(s_err),
    .o_held(s_held), .o_rep_cnt(s_cnt)
  );

  ir_key_decoder #(.EXT_ADDR(1'b1), .TIMEOUT_CYC(TO)) dut_ext (
    .clk(clk), .rst_n(rst_n), .i_data(i_data), .i_valid(i_valid),
    .i_repeat(i_repeat), .o_addr(x_addr), .o_cmd(x_cmd),
    .o_key_valid(x_kv), .o_rep(x_rep), .o_release(x_rel), .o_err(x_err),
    .o_held(x_held), .o_rep_cnt(x_cnt)
  );

  assign act_std = {s_kv, s_rep, s_rel, s_err, s_held, s_addr, s_cmd, s_cnt};
  assign act_ext = {x_kv, x_rep, x_rel, x_err, x_held, x_addr, x_cmd, x_cnt};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] data;
    logic        valid;
    logic        rep_in;
    logic [36:0] exp;
  } vec_t;

  vec_t vecs[13];

  function automatic logic [36:0] pack(input logic kv, input logic rp,
                                       input logic rl, input logic er,
                                       input logic hd, input logic [15:0] ad,
                                       input logic [7:0] cm,
                                       input logic [7:0] cn);
    return {kv, rp, rl, er, hd, ad, cm, cn};
  endfunction

  task automatic check_output(input string name, input logic [36:0] actual,
                              input logic [36:0] expected);
    checks++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  task automatic check_int(input string name, input int actual,
                           input int expected);
    checks++;
    if (actual != expected) begin
      fails++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  // Drive inputs before a rising edge, let it sample them, then return
  // 1 time unit after the edge with strobes cleared.
  task automatic apply_stimulus(input logic [31:0] d, input logic v,
                                input logic r);
    @(negedge clk);
    i_data   = d;
    i_valid  = v;
    i_repeat = r;
    @(posedge clk);
    #1;
    i_valid  = 1'b0;
    i_repeat = 1'b0;
  endtask

  task automatic do_reset;
    @(negedge clk);
    rst_n    = 1'b0;
    i_valid  = 1'b0;
    i_repeat = 1'b0;
    i_data   = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int release_at;
    int stray;

    checks   = 0;
    fails    = 0;
    rst_n    = 1'b0;
    i_data   = '0;
    i_valid  = 1'b0;
    i_repeat = 1'b0;

    vecs[0]  = '{"idle",        32'h0000_0000, 1'b0, 1'b0, pack(0,0,0,0,0,16'h0000,8'h00,8'd0)};
    vecs[1]  = '{"orphan_rep",  32'h0000_0000, 1'b0, 1'b1, pack(0,0,0,0,0,16'h0000,8'h00,8'd0)};
    vecs[2]  = '{"bad_cmd",     32'h00FF_18E6, 1'b1, 1'b0, pack(0,0,0,1,0,16'h0000,8'h00,8'd0)};
    vecs[3]  = '{"bad_addr",    32'h01FF_18E7, 1'b1, 1'b0, pack(0,0,0,1,0,16'h0000,8'h00,8'd0)};
    vecs[4]  = '{"good_18",     32'h00FF_18E7, 1'b1, 1'b0, pack(1,0,0,0,1,16'h0000,8'h18,8'd0)};
    vecs[5]  = '{"held_idle",   32'h0000_0000, 1'b0, 1'b0, pack(0,0,0,0,1,16'h0000,8'h18,8'd0)};
    vecs[6]  = '{"rep1",        32'h0000_0000, 1'b0, 1'b1, pack(0,1,0,0,1,16'h0000,8'h18,8'd1)};
    vecs[7]  = '{"rep2",        32'h0000_0000, 1'b0, 1'b1, pack(0,1,0,0,1,16'h0000,8'h18,8'd2)};
    vecs[8]  = '{"bad_in_held", 32'h00FF_18E6, 1'b1, 1'b0, pack(0,0,0,1,1,16'h0000,8'h18,8'd2)};
    vecs[9]  = '{"valid_and_rep",32'h00FF_45BA,1'b1, 1'b1, pack(1,0,0,0,1,16'h0000,8'h45,8'd0)};
    vecs[10] = '{"rep_after",   32'h0000_0000, 1'b0, 1'b1, pack(0,1,0,0,1,16'h0000,8'h45,8'd1)};
    vecs[11] = '{"held_idle2",  32'h0000_0000, 1'b0, 1'b0, pack(0,0,0,0,1,16'h0000,8'h45,8'd1)};
    vecs[12] = '{"new_key",     32'h10EF_08F7, 1'b1, 1'b0, pack(1,0,0,0,1,16'h0010,8'h08,8'd0)};

    // Reset state of both instances.
    do_reset();
    #1;
    check_output("reset_std", act_std, 37'd0);
    check_output("reset_ext", act_ext, 37'd0);

    // Vector table on the standard instance.
    for (int i = 0; i < 13; i++) begin
      apply_stimulus(vecs[i].data, vecs[i].valid, vecs[i].rep_in);
      check_output(vecs[i].name, act_std, vecs[i].exp);
    end

    // Repeats 50 cycles apart, then release exactly TO cycles later.
    do_reset();
    apply_stimulus(32'h00FF_18E7, 1'b1, 1'b0);
    check_output("to_press", act_std, pack(1,0,0,0,1,16'h0000,8'h18,8'd0));
    stray = 0;
    for (int r = 0; r < 3; r++) begin
      apply_stimulus(32'h0, 1'b0, 1'b1);
      check_output($sformatf("to_rep%0d", r + 1), act_std,
                   pack(0,1,0,0,1,16'h0000,8'h18,8'(r + 1)));
      if (r < 2) begin
        for (int k = 0; k < 49; k++) begin
          apply_stimulus(32'h0, 1'b0, 1'b0);
          if (s_rel !== 1'b0 || s_held !== 1'b1) stray++;
        end
      end
    end
    check_int("to_no_early_release", stray, 0);
    release_at = -1;
    for (int k = 1; k <= 150; k++) begin
      apply_stimulus(32'h0, 1'b0, 1'b0);
      if (s_rel === 1'b1) begin
        release_at = k;
        break;
      end
    end
    check_int("to_release_cycle", release_at, 100);
    check_output("to_release_state", act_std, pack(0,0,1,0,0,16'h0000,8'h18,8'd3));
    apply_stimulus(32'h0, 1'b0, 1'b0);
    check_output("to_after_release", act_std, pack(0,0,0,0,0,16'h0000,8'h18,8'd3));

    // Repeat arriving on the very cycle the timer expires wins.
    apply_stimulus(32'h00FF_18E7, 1'b1, 1'b0);
    for (int k = 0; k < 99; k++) apply_stimulus(32'h0, 1'b0, 1'b0);
    apply_stimulus(32'h0, 1'b0, 1'b1);
    check_output("expiry_rep_wins", act_std, pack(0,1,0,0,1,16'h0000,8'h18,8'd1));

    // Extended address mode and rep_cnt saturation.
    do_reset();
    apply_stimulus(32'h3412_18E7, 1'b1, 1'b0);
    check_output("ext_press", act_ext, pack(1,0,0,0,1,16'h1234,8'h18,8'd0));
    check_output("std_rejects_ext", act_std, pack(0,0,0,1,0,16'h0000,8'h00,8'd0));
    for (int k = 1; k <= 300; k++) begin
      apply_stimulus(32'h0, 1'b0, 1'b1);
      if (k == 254) check_int("ext_cnt_254", int'(x_cnt), 254);
      if (k == 255) check_int("ext_cnt_255", int'(x_cnt), 255);
    end
    check_output("ext_cnt_sat", act_ext, pack(0,1,0,0,1,16'h1234,8'h18,8'd255));

    // Asynchronous reset in the middle of a hold.
    do_reset();
    apply_stimulus(32'h00FF_18E7, 1'b1, 1'b0);
    apply_stimulus(32'h0, 1'b0, 1'b1);
    apply_stimulus(32'h0, 1'b0, 1'b1);
    check_output("pre_reset_hold", act_std, pack(0,1,0,0,1,16'h0000,8'h18,8'd2));
    #2;
    rst_n = 1'b0;
    #1;
    check_output("async_reset_std", act_std, 37'd0);
    check_output("async_reset_ext", act_ext, 37'd0);
    @(negedge clk);
    rst_n = 1'b1;
    apply_stimulus(32'h0, 1'b0, 1'b1);
    check_output("post_reset_orphan", act_std, 37'd0);
    apply_stimulus(32'h00FF_45BA, 1'b1, 1'b0);
    check_output("post_reset_press", act_std, pack(1,0,0,0,1,16'h0000,8'h45,8'd0));

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
